rbz_spi_sequencer: RTL and testbench

RBZ_SPI_SEQUENCER -- requirements
Module: rbz_spi_sequencer

---
 rtl/rbz_spi_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_rbz_spi_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rbz_spi_sequencer.sv
// Two-channel SPI frame sequencer: round-robin arbitration between a vector and a
// register slave, mode 0 MSB-first shifting, null-frame acknowledge.
module rbz_spi_sequencer #(
    parameter int unsigned HALF = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_vec_req,
    input  logic        i_reg_req,
    input  logic [5:0]  i_vec_len,
    input  logic [5:0]  i_reg_len,
    input  logic [31:0] i_vec_data,
    input  logic [31:0] i_reg_data,
    output logic        o_vec_done,
    output logic        o_reg_done,
    output logic        o_busy,
    output logic        o_vec_csb,
    output logic        o_vec_sclk,
    output logic        o_vec_mosi,
    output logic        o_reg_csb,
    output logic        o_reg_sclk,
    output logic        o_reg_mosi
);

    localparam int unsigned CW = 8;
    localparam int unsigned LW = 6;
    localparam int unsigned DW = 32;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(HALF - 2);
    localparam bit HALF_ONE = (HALF == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_NULLACK
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] bits_q, bits_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          chan_q, chan_d;   // 0 = vec, 1 = reg
    logic          prio_q, prio_d;   // 1 = reg wins a tie
    logic          csb_q, csb_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic          vec_csb_q, vec_csb_d, vec_sclk_q, vec_sclk_d, vec_mosi_q, vec_mosi_d;
    logic          reg_csb_q, reg_csb_d, reg_sclk_q, reg_sclk_d, reg_mosi_q, reg_mosi_d;
    logic          vec_done_q, vec_done_d, reg_done_q, reg_done_d, busy_q, busy_d;
    logic          done_d, grant_reg;
    logic [LW-1:0] req_len, clamp_len;
    logic [DW-1:0] req_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        sh_d      = sh_q;
        chan_d    = chan_q;
        prio_d    = prio_q;
        csb_d     = csb_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        grant_reg = i_reg_req && (prio_q || !i_vec_req);
        req_len   = grant_reg ? i_reg_len : i_vec_len;
        req_data  = grant_reg ? i_reg_data : i_vec_data;
        clamp_len = (req_len > 6'd32) ? 6'd32 : req_len;

        unique case (state_q)
            S_IDLE: begin
                csb_d  = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (i_vec_req || i_reg_req) begin
                    chan_d = grant_reg;
                    prio_d = !grant_reg;
                    cnt_d  = '0;
                    if (clamp_len == '0) begin
                        state_d = S_NULLACK;
                    end else begin
                        // Left-align so the first bit to send sits in the MSB.
                        bits_d  = clamp_len;
                        sh_d    = req_data << (6'd32 - clamp_len);
                        csb_d   = 1'b0;
                        mosi_d  = sh_d[DW-1];
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (sclk_q) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    sh_d   = {sh_q[DW-2:0], 1'b0};
                    mosi_d = sh_q[DW-2];
                    bits_d = bits_q - 6'd1;
                end else if (bits_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d  = '0;
                    sclk_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    csb_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = HALF_ONE;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                // done is registered, so it is launched one cycle ahead of the last GAP cycle.
                done_d = !HALF_ONE && (cnt_q == CNT_DONE);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_NULLACK: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        vec_csb_d  = chan_d ? 1'b1 : csb_d;
        vec_sclk_d = chan_d ? 1'b0 : sclk_d;
        vec_mosi_d = chan_d ? 1'b0 : mosi_d;
        reg_csb_d  = chan_d ? csb_d  : 1'b1;
        reg_sclk_d = chan_d ? sclk_d : 1'b0;
        reg_mosi_d = chan_d ? mosi_d : 1'b0;
        vec_done_d = done_d && !chan_q;
        reg_done_d = done_d && chan_q;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bits_q     <= '0;
            sh_q       <= '0;
            chan_q     <= 1'b0;
            prio_q     <= 1'b0;
            csb_q      <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            vec_csb_q  <= 1'b1;
            vec_sclk_q <= 1'b0;
            vec_mosi_q <= 1'b0;
            reg_csb_q  <= 1'b1;
            reg_sclk_q <= 1'b0;
            reg_mosi_q <= 1'b0;
            vec_done_q <= 1'b0;
            reg_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            sh_q       <= sh_d;
            chan_q     <= chan_d;
            prio_q     <= prio_d;
            csb_q      <= csb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            vec_csb_q  <= vec_csb_d;
            vec_sclk_q <= vec_sclk_d;
            vec_mosi_q <= vec_mosi_d;
            reg_csb_q  <= reg_csb_d;
            reg_sclk_q <= reg_sclk_d;
            reg_mosi_q <= reg_mosi_d;
            vec_done_q <= vec_done_d;
            reg_done_q <= reg_done_d;
            busy_q     <= busy_d;
        end
    end

    assign o_vec_csb  = vec_csb_q;
    assign o_vec_sclk = vec_sclk_q;
    assign o_vec_mosi = vec_mosi_q;
    assign o_reg_csb  = reg_csb_q;
    assign o_reg_sclk = reg_sclk_q;
    assign o_reg_mosi = reg_mosi_q;
    assign o_vec_done = vec_done_q;
    assign o_reg_done = reg_done_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_rbz_spi_sequencer.sv
// Bench for rbz_spi_sequencer: a negedge bus monitor captures each frame, and the
// stimulus side compares it against an expected-frame queue.
module tb_rbz_spi_sequencer;

    localparam int H = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_vec_req = 1'b0, i_reg_req = 1'b0;
    logic [5:0]  i_vec_len = '0, i_reg_len = '0;
    logic [31:0] i_vec_data = '0, i_reg_data = '0;
    logic        o_vec_done, o_reg_done, o_busy;
    logic        o_vec_csb, o_vec_sclk, o_vec_mosi;
    logic        o_reg_csb, o_reg_sclk, o_reg_mosi;

    rbz_spi_sequencer #(.HALF(H)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_vec_req(i_vec_req), .i_reg_req(i_reg_req),
        .i_vec_len(i_vec_len), .i_reg_len(i_reg_len),
        .i_vec_data(i_vec_data), .i_reg_data(i_reg_data),
        .o_vec_done(o_vec_done), .o_reg_done(o_reg_done), .o_busy(o_busy),
        .o_vec_csb(o_vec_csb), .o_vec_sclk(o_vec_sclk), .o_vec_mosi(o_vec_mosi),
        .o_reg_csb(o_reg_csb), .o_reg_sclk(o_reg_sclk), .o_reg_mosi(o_reg_mosi)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          ch;
        int          n;
        logic [31:0] bits;
        int          low;
    } obs_t;

    typedef struct {
        int          ch;
        int          n;
        logic [31:0] bits;
    } exp_t;

    typedef struct {
        bit          ch;
        logic [5:0]  len;
        logic [31:0] data;
        int          en;
        logic [31:0] eb;
    } vec_t;

    // Monitor state, written only by the monitor process.
    obs_t        obs_mem [128];
    int          obs_wr = 0;
    int          viol = 0;
    int          nb [2];
    int          low [2];
    logic [31:0] cap [2];
    logic [1:0]  pcsb = 2'b11, psclk = 2'b00, pmosi = 2'b00;
    logic [1:0]  m_csb, m_sclk, m_mosi, m_done;

    always @(negedge i_clk) begin
        m_csb  = {o_reg_csb, o_vec_csb};
        m_sclk = {o_reg_sclk, o_vec_sclk};
        m_mosi = {o_reg_mosi, o_vec_mosi};
        m_done = {o_reg_done, o_vec_done};
        if (!m_csb[0] && !m_csb[1]) begin
            viol++;
            $display("invariant: both chip selects low at %0t", $time);
        end
        for (int c = 0; c < 2; c++) begin
            if (m_csb[c] && (m_sclk[c] || m_mosi[c])) begin
                viol++;
                $display("invariant: ch%0d sclk/mosi active with csb high at %0t", c, $time);
            end
            if (m_sclk[c] && psclk[c] && (m_mosi[c] != pmosi[c])) begin
                viol++;
                $display("invariant: ch%0d mosi moved while sclk high at %0t", c, $time);
            end
            if (i_reset) begin
                nb[c] = 0; low[c] = 0; cap[c] = '0;
            end else begin
                if (!m_csb[c]) begin
                    if (pcsb[c]) begin
                        nb[c] = 0; low[c] = 0; cap[c] = '0;
                    end
                    low[c]++;
                    if (m_sclk[c] && !psclk[c]) begin
                        cap[c] = {cap[c][30:0], m_mosi[c]};
                        nb[c]++;
                    end
                end
                if (m_done[c]) begin
                    obs_mem[obs_wr % 128] = '{c, nb[c], cap[c], low[c]};
                    obs_wr++;
                    nb[c] = 0; low[c] = 0; cap[c] = '0;
                end
            end
        end
        pcsb  = m_csb;
        psclk = m_sclk;
        pmosi = m_mosi;
    end

    // Stimulus / scoreboard side.
    int   total = 0;
    int   bad = 0;
    int   obs_rd = 0;
    exp_t exp_q[$];
    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Wait for the next done pulse, then compare the captured frame with the queue head.
    task automatic collect(input bit mut, input bit mch, output int lat, output int busy_n);
        bit   mutated = 1'b0;
        bit   seen = 1'b0;
        exp_t e;
        obs_t o;
        lat = 0;
        busy_n = 0;
        while (!seen && lat < 2000) begin
            @(negedge i_clk);
            lat++;
            busy_n += int'(o_busy);
            seen = o_vec_done || o_reg_done;
            if (mut && !mutated && ((!mch && !o_vec_csb) || (mch && !o_reg_csb))) begin
                if (!mch) begin
                    i_vec_data = ~i_vec_data; i_vec_len = 6'd5;
                end else begin
                    i_reg_data = ~i_reg_data; i_reg_len = 6'd5;
                end
                mutated = 1'b1;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        if (!seen) return;
        #1;
        check("record_present", 64'(obs_wr > obs_rd), 64'd1);
        if (obs_wr <= obs_rd || exp_q.size() == 0) return;
        o = obs_mem[obs_rd % 128];
        obs_rd++;
        e = exp_q.pop_front();
        check("frame_chan", 64'(o.ch), 64'(e.ch));
        check("frame_nbits", 64'(o.n), 64'(e.n));
        check("frame_bits", 64'(o.bits), 64'(e.bits));
        check("csb_low_cycles", 64'(o.low), 64'((e.n == 0) ? 0 : 2 * H * (e.n + 1)));
    endtask

    task automatic run_frame(input bit ch, input logic [5:0] len, input logic [31:0] data,
                             input int en, input logic [31:0] eb, input bit mut);
        int lat, busy_n;
        exp_q.push_back('{int'(ch), en, eb});
        if (!ch) begin
            i_vec_len = len; i_vec_data = data; i_vec_req = 1'b1;
        end else begin
            i_reg_len = len; i_reg_data = data; i_reg_req = 1'b1;
        end
        collect(mut, ch, lat, busy_n);
        i_vec_req = 1'b0;
        i_reg_req = 1'b0;
        check("done_latency", 64'(lat), 64'((en == 0) ? 2 : 2 * H * (en + 1) + H));
        if (en == 0) check("null_busy_cycles", 64'(busy_n), 64'd1);
        @(negedge i_clk);
    endtask

    initial begin
        int lat, busy_n, cyc, done_cnt, wr0;
        tbl[0] = '{1'b0, 6'd8,  32'h0000_00A5, 8,  32'h0000_00A5};
        tbl[1] = '{1'b1, 6'd0,  32'hFFFF_FFFF, 0,  32'h0};
        tbl[2] = '{1'b0, 6'd40, 32'hFFFF_0000, 32, 32'hFFFF_0000};
        tbl[3] = '{1'b1, 6'd5,  32'h0000_003F, 5,  32'h0000_001F};
        tbl[4] = '{1'b0, 6'd1,  32'h0000_0001, 1,  32'h0000_0001};
        tbl[5] = '{1'b1, 6'd32, 32'h1234_5678, 32, 32'h1234_5678};
        tbl[6] = '{1'b0, 6'd33, 32'hDEAD_BEEF, 32, 32'hDEAD_BEEF};
        tbl[7] = '{1'b1, 6'd3,  32'h0000_0006, 3,  32'h0000_0006};
        tbl[8] = '{1'b0, 6'd0,  32'h0000_0000, 0,  32'h0};

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs",
              64'({o_vec_csb, o_vec_sclk, o_vec_mosi, o_reg_csb, o_reg_sclk, o_reg_mosi,
                   o_vec_done, o_reg_done, o_busy}), 64'(9'b100_100_000));
        i_reset = 1'b0;
        @(negedge i_clk);

        foreach (tbl[i])
            run_frame(tbl[i].ch, tbl[i].len, tbl[i].data, tbl[i].en, tbl[i].eb, 1'b0);

        // Data and length changed mid-frame must not affect the frame in flight.
        run_frame(1'b0, 6'd12, 32'h0000_0B6D, 12, 32'h0000_0B6D, 1'b1);
        run_frame(1'b1, 6'd10, 32'h0000_02C3, 10, 32'h0000_02C3, 1'b1);

        // Reset in the middle of a 16-bit vec frame.
        i_vec_len = 6'd16; i_vec_data = 32'h0000_C3A5; i_vec_req = 1'b1;
        cyc = 0;
        while (nb[0] != 3 && cyc < 500) begin
            @(negedge i_clk);
            cyc++;
        end
        check("abort_reached_bit3", 64'(nb[0]), 64'd3);
        wr0 = obs_wr;
        i_reset = 1'b1;
        i_vec_req = 1'b0;
        @(negedge i_clk);
        check("abort_vec_pins", 64'({o_vec_csb, o_vec_sclk, o_vec_mosi}), 64'(3'b100));
        check("abort_busy", 64'(o_busy), 64'd0);
        i_reset = 1'b0;
        done_cnt = 0;
        repeat (100) begin
            @(negedge i_clk);
            done_cnt += int'(o_vec_done) + int'(o_reg_done);
        end
        check("abort_no_done", 64'(done_cnt + obs_wr - wr0), 64'd0);
        run_frame(1'b0, 6'd16, 32'h0000_C3A5, 16, 32'h0000_C3A5, 1'b0);

        // Both requests held through and after reset: frames alternate vec, reg, vec, reg.
        i_reset = 1'b1;
        i_vec_len = 6'd4; i_vec_data = 32'h0000_0009; i_vec_req = 1'b1;
        i_reg_len = 6'd6; i_reg_data = 32'h0000_0031; i_reg_req = 1'b1;
        busy_n = 0;
        repeat (3) begin
            @(negedge i_clk);
            busy_n += int'(o_busy);
        end
        check("no_grant_in_reset", 64'(busy_n), 64'd0);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{0, 4, 32'h9});
            exp_q.push_back('{1, 6, 32'h31});
        end
        i_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            collect(1'b0, 1'b0, lat, busy_n);
            if (k == 0) check("rr_first_latency", 64'(lat), 64'(2 * H * 5 + H));
        end
        i_vec_req = 1'b0;
        i_reg_req = 1'b0;
        repeat (5) @(negedge i_clk);

        check("invariant_violations", 64'(viol), 64'd0);
        check("stray_done_records", 64'(obs_wr - obs_rd), 64'd0);
        check("unconsumed_expected", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
